// File: rtl/pio_reader_pkg.sv
// Shared types and status-bit layout for the multi-channel PIO FIFO reader.
// Build option: PIO_READER_TIMESTAMP_EN (see pio_fifo_reader).
package pio_reader_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    POP     = 2'd1,
    WAIT    = 2'd2,
    CAPTURE = 2'd3
  } state_t;

  localparam int ST_ACK    = 0;
  localparam int ST_VALID  = 1;
  localparam int ST_UFLOW  = 2;
  localparam int ST_BUSY   = 3;
  localparam int ST_BADCH  = 4;
  localparam int ST_CH_LSB = 5;

  localparam int CH_SEL_W = 3;
  localparam int LAT_W    = 2;

  function automatic logic chInRange(input logic [CH_SEL_W-1:0] ch, input int numCh);
    return (int'(ch) < numCh);
  endfunction

endpackage

// File: rtl/pio_reader_chan_mux.sv
// Combinational channel selection (q, empty, usedw) and per-channel threshold compare.
// Two selectors: the live HPS select and the channel latched for the capture in flight.
module pio_reader_chan_mux
  import pio_reader_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int WORD_W  = 16,
  parameter int USEDW_W = 12
) (
  input  logic [CH_SEL_W-1:0]       sel_i,
  input  logic [CH_SEL_W-1:0]       capSel_i,
  input  logic [NUM_CH*WORD_W-1:0]  fifoQ_i,
  input  logic [NUM_CH-1:0]         fifoEmpty_i,
  input  logic [NUM_CH*USEDW_W-1:0] fifoUsedw_i,
  input  logic [USEDW_W-1:0]        threshold_i,
  output logic                      selValid_o,
  output logic                      selEmpty_o,
  output logic [USEDW_W-1:0]        selUsedw_o,
  output logic [WORD_W-1:0]         capQ_o,
  output logic [NUM_CH-1:0]         aboveThr_o
);

  // An out-of-range select reads as empty with a zero fill count.
  always_comb begin
    selValid_o = chInRange(sel_i, NUM_CH);
    selEmpty_o = 1'b1;
    selUsedw_o = '0;
    capQ_o     = '0;
    aboveThr_o = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel_i == CH_SEL_W'(i)) begin
        selEmpty_o = fifoEmpty_i[i];
        selUsedw_o = fifoUsedw_i[i*USEDW_W +: USEDW_W];
      end
      if (capSel_i == CH_SEL_W'(i)) begin
        capQ_o = fifoQ_i[i*WORD_W +: WORD_W];
      end
      aboveThr_o[i] = (fifoUsedw_i[i*USEDW_W +: USEDW_W] >= threshold_i);
    end
  end

endmodule

// File: rtl/pio_fifo_reader.sv
// Drains NUM_CH sample FIFOs one word per HPS toggle request, with sticky error status.
// Build option: define PIO_READER_TIMESTAMP_EN to add the hps_timestamp capture port.
module pio_fifo_reader
  import pio_reader_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int WORD_W  = 16,
  parameter int USEDW_W = 12,
  parameter int RD_LAT  = 1
) (
  input  logic                      clk_clk,
  input  logic                      reset_reset_n,
  input  logic [7:0]                hps_read_clk,
  input  logic [7:0]                hps_read_rq,
  input  logic [USEDW_W-1:0]        hps_threshold,
  input  logic [NUM_CH*WORD_W-1:0]  fifo_q,
  input  logic [NUM_CH-1:0]         fifo_empty,
  input  logic [NUM_CH*USEDW_W-1:0] fifo_usedw,
  output logic [NUM_CH-1:0]         fifo_rdreq,
  output logic [WORD_W-1:0]         hps_word,
  output logic [7:0]                hps_read_status,
  output logic [NUM_CH-1:0]         hps_ready_mask,
  output logic [USEDW_W-1:0]        hps_usedw
`ifdef PIO_READER_TIMESTAMP_EN
  ,
  output logic [31:0]               hps_timestamp
`endif
);

  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(RD_LAT - 1);

  state_t               state_q, state_d;
  logic                 reqSeen_q, reqSeen_d;
  logic [CH_SEL_W-1:0]  ch_q, ch_d;
  logic [LAT_W-1:0]     latCnt_q, latCnt_d;
  logic [WORD_W-1:0]    word_q, word_d;
  logic                 ack_q, ack_d;
  logic                 valid_q, valid_d;
  logic                 uflow_q, uflow_d;
  logic                 badCh_q, badCh_d;
  logic [CH_SEL_W-1:0]  servedCh_q, servedCh_d;
  logic [NUM_CH-1:0]    readyMask_q;
  logic [USEDW_W-1:0]   usedw_q;

  logic                 request;
  logic                 busy;
  logic                 selValid;
  logic                 selEmpty;
  logic [USEDW_W-1:0]   selUsedw;
  logic [WORD_W-1:0]    capQ;
  logic [NUM_CH-1:0]    aboveThr;
  logic [CH_SEL_W-1:0]  selCh;
  logic                 unusedPioBits;

  assign selCh         = hps_read_rq[CH_SEL_W-1:0];
  assign request       = (hps_read_clk[0] != reqSeen_q);
  assign unusedPioBits = ^{hps_read_clk[7:1], hps_read_rq[6:CH_SEL_W]};

  pio_reader_chan_mux #(
    .NUM_CH  (NUM_CH),
    .WORD_W  (WORD_W),
    .USEDW_W (USEDW_W)
  ) u_chan_mux (
    .sel_i       (selCh),
    .capSel_i    (ch_q),
    .fifoQ_i     (fifo_q),
    .fifoEmpty_i (fifo_empty),
    .fifoUsedw_i (fifo_usedw),
    .threshold_i (hps_threshold),
    .selValid_o  (selValid),
    .selEmpty_o  (selEmpty),
    .selUsedw_o  (selUsedw),
    .capQ_o      (capQ),
    .aboveThr_o  (aboveThr)
  );

  // WAIT exits when the counter reaches zero, giving RD_LAT-1 wait cycles.
  always_comb begin
    state_d   = state_q;
    reqSeen_d = reqSeen_q;
    ch_d      = ch_q;
    latCnt_d  = latCnt_q;
    unique case (state_q)
      IDLE: begin
        if (request) begin
          reqSeen_d = hps_read_clk[0];
          ch_d      = selCh;
          if (selValid && !selEmpty) state_d = POP;
        end
      end
      POP: begin
        latCnt_d = LAT_LOAD;
        state_d  = (RD_LAT == 1) ? CAPTURE : WAIT;
      end
      WAIT: begin
        latCnt_d = latCnt_q - 1'b1;
        if (latCnt_q == LAT_W'(1)) state_d = CAPTURE;
      end
      CAPTURE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q != IDLE);
    fifo_rdreq = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      fifo_rdreq[i] = (state_q == POP) && (ch_q == CH_SEL_W'(i));
    end
    hps_read_status                            = '0;
    hps_read_status[ST_ACK]                    = ack_q;
    hps_read_status[ST_VALID]                  = valid_q;
    hps_read_status[ST_UFLOW]                  = uflow_q;
    hps_read_status[ST_BUSY]                   = busy;
    hps_read_status[ST_BADCH]                  = badCh_q;
    hps_read_status[ST_CH_LSB +: CH_SEL_W]     = servedCh_q;
  end

  // Error acks complete in IDLE without touching the word; a clear beats a same-cycle set.
  always_comb begin
    word_d     = word_q;
    ack_d      = ack_q;
    valid_d    = valid_q;
    uflow_d    = uflow_q;
    badCh_d    = badCh_q;
    servedCh_d = servedCh_q;
    if ((state_q == IDLE) && request) begin
      if (!selValid) begin
        badCh_d = 1'b1;
        valid_d = 1'b0;
        ack_d   = ~ack_q;
      end else if (selEmpty) begin
        uflow_d = 1'b1;
        valid_d = 1'b0;
        ack_d   = ~ack_q;
      end
    end
    if (state_q == CAPTURE) begin
      word_d     = capQ;
      valid_d    = 1'b1;
      servedCh_d = ch_q;
      ack_d      = ~ack_q;
    end
    if (hps_read_rq[7]) begin
      uflow_d = 1'b0;
      badCh_d = 1'b0;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q     <= IDLE;
      reqSeen_q   <= 1'b0;
      ch_q        <= '0;
      latCnt_q    <= '0;
      word_q      <= '0;
      ack_q       <= 1'b0;
      valid_q     <= 1'b0;
      uflow_q     <= 1'b0;
      badCh_q     <= 1'b0;
      servedCh_q  <= '0;
      readyMask_q <= '0;
      usedw_q     <= '0;
    end else begin
      state_q     <= state_d;
      reqSeen_q   <= reqSeen_d;
      ch_q        <= ch_d;
      latCnt_q    <= latCnt_d;
      word_q      <= word_d;
      ack_q       <= ack_d;
      valid_q     <= valid_d;
      uflow_q     <= uflow_d;
      badCh_q     <= badCh_d;
      servedCh_q  <= servedCh_d;
      readyMask_q <= aboveThr;
      usedw_q     <= selValid ? selUsedw : '0;
    end
  end

  assign hps_word       = word_q;
  assign hps_ready_mask = readyMask_q;
  assign hps_usedw      = usedw_q;

`ifdef PIO_READER_TIMESTAMP_EN
  logic [31:0] tsCnt_q, tsCnt_d;
  logic [31:0] ts_q, ts_d;

  always_comb begin
    tsCnt_d = tsCnt_q + 32'd1;
    ts_d    = (state_q == CAPTURE) ? tsCnt_q : ts_q;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      tsCnt_q <= '0;
      ts_q    <= '0;
    end else begin
      tsCnt_q <= tsCnt_d;
      ts_q    <= ts_d;
    end
  end

  assign hps_timestamp = ts_q;
`endif

endmodule

// File: tb/tb_pio_fifo_reader.sv
// Scoreboard bench for pio_fifo_reader: queue-based FIFO/reference models, randomized requests.
// Honours PIO_READER_TIMESTAMP_EN when the design is built with it.
module tb_pio_fifo_reader;
  localparam int NUM_CH  = 4;
  localparam int WORD_W  = 16;
  localparam int USEDW_W = 12;
  localparam int RD_LAT  = 3;

  logic                      clk_clk = 1'b0;
  logic                      reset_reset_n = 1'b0;
  logic [7:0]                hps_read_clk = '0;
  logic [7:0]                hps_read_rq = '0;
  logic [USEDW_W-1:0]        hps_threshold = '0;
  logic [NUM_CH*WORD_W-1:0]  fifo_q = '0;
  logic [NUM_CH-1:0]         fifo_empty = '1;
  logic [NUM_CH*USEDW_W-1:0] fifo_usedw = '0;
  logic [NUM_CH-1:0]         fifo_rdreq;
  logic [WORD_W-1:0]         hps_word;
  logic [7:0]                hps_read_status;
  logic [NUM_CH-1:0]         hps_ready_mask;
  logic [USEDW_W-1:0]        hps_usedw;
`ifdef PIO_READER_TIMESTAMP_EN
  logic [31:0]               hps_timestamp;
`endif

  pio_fifo_reader #(
    .NUM_CH(NUM_CH), .WORD_W(WORD_W), .USEDW_W(USEDW_W), .RD_LAT(RD_LAT)
  ) dut (
    .clk_clk         (clk_clk),
    .reset_reset_n   (reset_reset_n),
    .hps_read_clk    (hps_read_clk),
    .hps_read_rq     (hps_read_rq),
    .hps_threshold   (hps_threshold),
    .fifo_q          (fifo_q),
    .fifo_empty      (fifo_empty),
    .fifo_usedw      (fifo_usedw),
    .fifo_rdreq      (fifo_rdreq),
    .hps_word        (hps_word),
    .hps_read_status (hps_read_status),
    .hps_ready_mask  (hps_ready_mask),
    .hps_usedw       (hps_usedw)
`ifdef PIO_READER_TIMESTAMP_EN
    ,
    .hps_timestamp   (hps_timestamp)
`endif
  );

  always #5 clk_clk = ~clk_clk;

  typedef struct {
    logic [WORD_W-1:0] word;
    logic [7:0]        status;
    int                issueCycle;
    int                latency;
    int                pulses;
    logic [NUM_CH-1:0] rdMask;
    logic              good;
  } exp_t;

  int checks = 0;
  int errors = 0;
  int cycleCnt = 0;
  exp_t sb[$];

  logic [WORD_W-1:0] fifoMem [NUM_CH][$];
  logic [WORD_W-1:0] refMem  [NUM_CH][$];
  int                pendCnt [NUM_CH];
  logic [WORD_W-1:0] pendWord[NUM_CH];

  logic              refAck = 1'b0;
  logic              refValid = 1'b0;
  logic              refUflow = 1'b0;
  logic              refBad = 1'b0;
  logic [2:0]        refServed = '0;
  logic [WORD_W-1:0] refWord = '0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, actual, expected, cycleCnt);
    end
  endtask

  always @(posedge clk_clk) cycleCnt++;

  // FIFO model: a pop strobe seen in the POP cycle makes the word visible RD_LAT edges later; junk until then.
  always @(negedge clk_clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (pendCnt[c] > 0) begin
        pendCnt[c]--;
        if (pendCnt[c] == 0) fifo_q[c*WORD_W +: WORD_W] = pendWord[c];
      end
      if (fifo_rdreq[c]) begin
        pendWord[c] = (fifoMem[c].size() > 0) ? fifoMem[c].pop_front() : 16'hDEAD;
        pendCnt[c]  = RD_LAT;
        fifo_q[c*WORD_W +: WORD_W] = ~pendWord[c];
      end
      fifo_empty[c] = (fifoMem[c].size() == 0);
    end
  end

`ifdef PIO_READER_TIMESTAMP_EN
  int tsCycles = 0;
  logic [31:0] refTs = '0;
  always @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) tsCycles = 0;
    else tsCycles++;
  end
`endif

  logic lastAck = 1'b0;
  int rdPulses = 0;
  logic [NUM_CH-1:0] rdSeen = '0;
  exp_t monE;

  // Monitor: every ack toggle consumes one scoreboard entry.
  always @(negedge clk_clk) begin
    if (!reset_reset_n) begin
      lastAck = 1'b0;
      rdPulses = 0;
      rdSeen = '0;
`ifdef PIO_READER_TIMESTAMP_EN
      refTs = '0;
`endif
    end else begin
      if (fifo_rdreq != '0) begin
        rdPulses++;
        rdSeen |= fifo_rdreq;
      end
      if (hps_read_status[0] != lastAck) begin
        lastAck = hps_read_status[0];
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_ack: got ack toggle expected none at cycle %0d", cycleCnt);
        end else begin
          monE = sb.pop_front();
          checkOutput("word", 32'(hps_word), 32'(monE.word));
          checkOutput("status", 32'(hps_read_status), 32'(monE.status));
          checkOutput("latency", cycleCnt - monE.issueCycle, monE.latency);
          checkOutput("rdreq_pulses", rdPulses, monE.pulses);
          checkOutput("rdreq_mask", 32'(rdSeen), 32'(monE.rdMask));
`ifdef PIO_READER_TIMESTAMP_EN
          if (monE.good) refTs = 32'(tsCycles - 1);
          checkOutput("timestamp", hps_timestamp, refTs);
`endif
        end
        rdPulses = 0;
        rdSeen = '0;
      end
    end
  end

  task automatic pushWord(input int c, input logic [WORD_W-1:0] w);
    fifoMem[c].push_back(w);
    refMem[c].push_back(w);
  endtask

  task automatic applyStimulus(input int ch, input logic clr);
    exp_t e;
    int n;
    e.good = 1'b0;
    e.pulses = 0;
    e.rdMask = '0;
    e.latency = 1;
    if (ch >= NUM_CH) begin
      refBad = 1'b1;
      refValid = 1'b0;
    end else if (refMem[ch].size() == 0) begin
      refUflow = 1'b1;
      refValid = 1'b0;
    end else begin
      e.good = 1'b1;
      refWord = refMem[ch].pop_front();
      refValid = 1'b1;
      refServed = 3'(ch);
      e.latency = RD_LAT + 2;
      e.pulses = 1;
      e.rdMask = NUM_CH'(1) << ch;
    end
    if (clr) begin
      refUflow = 1'b0;
      refBad = 1'b0;
    end
    refAck = ~refAck;
    e.status = {refServed, refBad, 1'b0, refUflow, refValid, refAck};
    e.word = refWord;
    e.issueCycle = cycleCnt;
    sb.push_back(e);
    hps_read_rq = {clr, 4'b0, 3'(ch)};
    hps_read_clk[0] = ~hps_read_clk[0];
    n = 0;
    do begin
      @(negedge clk_clk);
      n++;
      if (n == 1) hps_read_rq[7] = 1'b0;
    end while (hps_read_status[0] !== refAck && n < 40);
    if (hps_read_status[0] !== refAck) begin
      checks++;
      errors++;
      $display("[TB] FAIL ack_timeout: got ack %b expected %b on ch %0d", hps_read_status[0], refAck, ch);
    end
  endtask

  task automatic clearSticky();
    hps_read_rq[7] = 1'b1;
    @(negedge clk_clk);
    hps_read_rq[7] = 1'b0;
    refBad = 1'b0;
    refUflow = 1'b0;
    checkOutput("sticky_clear", {30'b0, hps_read_status[4], hps_read_status[2]}, {30'b0, refBad, refUflow});
  endtask

  task automatic checkThreshold(input logic [NUM_CH*USEDW_W-1:0] u, input logic [USEDW_W-1:0] thr, input int sel);
    logic [NUM_CH-1:0] expMask;
    logic [USEDW_W-1:0] expUsedw;
    fifo_usedw = u;
    hps_threshold = thr;
    hps_read_rq[2:0] = 3'(sel);
    expMask = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (int'(u[i*USEDW_W +: USEDW_W]) >= int'(thr)) expMask[i] = 1'b1;
    end
    expUsedw = (sel < NUM_CH) ? u[sel*USEDW_W +: USEDW_W] : '0;
    @(negedge clk_clk);
    checkOutput("ready_mask", 32'(hps_ready_mask), 32'(expMask));
    checkOutput("usedw", 32'(hps_usedw), 32'(expUsedw));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #2;
    checkOutput("reset_word", 32'(hps_word), 32'h0);
    checkOutput("reset_status", 32'(hps_read_status), 32'h0);
    checkOutput("reset_rdreq", 32'(fifo_rdreq), 32'h0);
    checkOutput("reset_mask", 32'(hps_ready_mask), 32'h0);
    repeat (2) @(negedge clk_clk);
    reset_reset_n = 1'b1;
    @(negedge clk_clk);

    $display("[TB] directed: good read, underflow, bad channel, clear");
    pushWord(1, 16'hBEEF);
    @(negedge clk_clk);
    applyStimulus(1, 1'b0);
    applyStimulus(2, 1'b0);
    applyStimulus(6, 1'b0);
    clearSticky();
    applyStimulus(5, 1'b1);

    $display("[TB] directed: threshold mask");
    checkThreshold({12'd100, 12'd20, 12'd50, 12'd49}, 12'd50, 1);
    checkThreshold({12'd100, 12'd20, 12'd50, 12'd50}, 12'd50, 0);
    checkThreshold({12'd4095, 12'd0, 12'd1, 12'd4094}, 12'd4095, 7);

    $display("[TB] directed: back-to-back reads on ch0");
    for (int i = 0; i < 8; i++) pushWord(0, 16'(i));
    @(negedge clk_clk);
    for (int i = 0; i < 8; i++) applyStimulus(0, 1'b0);

    $display("[TB] directed: reset during WAIT");
    pushWord(0, 16'h1234);
    pushWord(0, 16'h5678);
    @(negedge clk_clk);
    hps_read_rq = '0;
    hps_read_clk[0] = ~hps_read_clk[0];
    repeat (2) @(negedge clk_clk);
    checkOutput("busy_in_wait", 32'(hps_read_status[3]), 32'h1);
    reset_reset_n = 1'b0;
    #1;
    checkOutput("rst_word", 32'(hps_word), 32'h0);
    checkOutput("rst_status", 32'(hps_read_status), 32'h0);
    checkOutput("rst_rdreq", 32'(fifo_rdreq), 32'h0);
    checkOutput("rst_mask", 32'(hps_ready_mask), 32'h0);
    checkOutput("rst_usedw", 32'(hps_usedw), 32'h0);
`ifdef PIO_READER_TIMESTAMP_EN
    checkOutput("rst_timestamp", hps_timestamp, 32'h0);
`endif
    void'(refMem[0].pop_front());
    refAck = 1'b0;
    refValid = 1'b0;
    refUflow = 1'b0;
    refBad = 1'b0;
    refServed = '0;
    refWord = '0;
    hps_read_clk[0] = 1'b0;
    @(negedge clk_clk);
    reset_reset_n = 1'b1;
    @(negedge clk_clk);
    applyStimulus(0, 1'b0);

    $display("[TB] random phase");
    for (int it = 0; it < 60; it++) begin
      int ch;
      logic clr;
      int nPush;
      nPush = $urandom_range(0, 2);
      for (int k = 0; k < nPush; k++) pushWord($urandom_range(0, NUM_CH - 1), WORD_W'($urandom));
      if (nPush > 0) @(negedge clk_clk);
      ch = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 7) : $urandom_range(0, NUM_CH - 1);
      clr = ($urandom_range(0, 5) == 0);
      applyStimulus(ch, clr);
      if ($urandom_range(0, 4) == 0) clearSticky();
      if ($urandom_range(0, 3) == 0) begin
        logic [USEDW_W-1:0] thr;
        logic [NUM_CH*USEDW_W-1:0] u;
        thr = USEDW_W'($urandom);
        for (int i = 0; i < NUM_CH; i++) begin
          case ($urandom_range(0, 2))
            0: u[i*USEDW_W +: USEDW_W] = thr;
            1: u[i*USEDW_W +: USEDW_W] = thr - 1'b1;
            default: u[i*USEDW_W +: USEDW_W] = USEDW_W'($urandom);
          endcase
        end
        checkThreshold(u, thr, $urandom_range(0, 7));
      end
    end

    repeat (4) @(negedge clk_clk);
    checkOutput("sb_drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
